// File: rtl/rv_muldiv_div.sv
`default_nettype none
// ============================================================================
// Module      : rv_muldiv_div (with helper adder_subtractor)
// Description : Iterative radix-2 restoring divider for RV32M
//               DIV / DIVU / REM / REMU. Produces one quotient bit per cycle,
//               with a fixed sign-fix cycle and a single-cycle fast path for
//               divide-by-zero and signed overflow.
// Ports       : clk    - clock, all state changes on rising edge
//               rst    - synchronous active-high reset
//               start  - request, accepted only when busy=0
//               op     - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//               a, b   - dividend / divisor, sampled on accept
//               kill   - synchronous abort (pipeline flush)
//               busy   - high whenever the unit is not idle
//               done   - one-cycle pulse, result valid that cycle
//               result - quotient or remainder, held until next update
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder_subtractor: r = a + b (sub=0) or r = a - b (sub=1), modulo 2^N.
// ----------------------------------------------------------------------------
module adder_subtractor #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] r
);
    // Two's complement subtract: invert b and inject the carry-in.
    assign r = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};
endmodule

// ----------------------------------------------------------------------------
// rv_muldiv_div: top-level divider.
// ----------------------------------------------------------------------------
module rv_muldiv_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            c_cnt_w = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ones = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operation context captured at accept
    logic               r_is_rem;
    logic               r_a_neg;   // only ever set for signed ops
    logic               r_b_neg;   // only ever set for signed ops
    logic [XLEN-1:0]    r_dvd;     // dividend magnitude, becomes the quotient
    logic [XLEN-1:0]    r_rem;     // partial remainder
    logic [XLEN-1:0]    r_dvs;     // divisor magnitude
    logic [c_cnt_w-1:0] r_count;
    logic [XLEN-1:0]    r_result;

    // Accept-time decode
    logic            w_accept;
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_result;

    // Iteration datapath
    logic [XLEN:0]   w_shift_rem;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;

    // Post-fix datapath
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    // kill in IDLE wins over start, so the request is simply dropped.
    assign w_accept = (r_state == S_IDLE) && start && !kill;
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[XLEN-1];
    assign w_b_neg  = w_signed & b[XLEN-1];
    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

    assign w_div0   = (b == '0);
    assign w_ovf    = w_signed && (a == c_min) && (b == c_ones);
    assign w_fast   = w_div0 || w_ovf;

    always_comb begin
        w_fast_result = '0;
        if (w_div0) begin
            w_fast_result = op[1] ? a : c_ones;
        end else begin
            w_fast_result = op[1] ? '0 : c_min;
        end
    end

    // Bring the next dividend bit into the remainder and trial-subtract.
    // Since rem < divisor, the shifted value is < 2*divisor, so a clear MSB
    // of the XLEN+1-bit difference means the subtraction did not underflow.
    assign w_shift_rem = {r_rem, r_dvd[XLEN-1]};

    adder_subtractor #(
        .N (XLEN + 1)
    ) u_trial_sub (
        .a   (w_shift_rem),
        .b   ({1'b0, r_dvs}),
        .sub (1'b1),
        .r   (w_diff)
    );

    assign w_qbit    = ~w_diff[XLEN];

    assign w_quo_fix = (r_a_neg ^ r_b_neg) ? (~r_dvd + 1'b1) : r_dvd;
    assign w_rem_fix = r_a_neg ? (~r_rem + 1'b1) : r_rem;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                w_state_nxt = kill ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_rem <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op[1];
                        r_a_neg  <= w_a_neg;
                        r_b_neg  <= w_b_neg;
                        r_dvd    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_rem    <= '0;
                        r_count  <= c_cnt_w'(XLEN - 1);
                        if (w_fast) begin
                            r_result <= w_fast_result;
                        end
                    end
                end
                S_CALC: begin
                    if (!kill) begin
                        r_rem   <= w_qbit ? w_diff[XLEN-1:0] : w_shift_rem[XLEN-1:0];
                        r_dvd   <= {r_dvd[XLEN-2:0], w_qbit};
                        r_count <= r_count - 1'b1;
                    end
                end
                S_FIX: begin
                    if (!kill) begin
                        r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/rv_muldiv_div.md
Name: rv_muldiv_div

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the ALU and stalls the pipeline while busy.
- Feeds its partial remainder and divisor into an internal adder_subtractor instance (N=XLEN+1, sub=1) each cycle and consumes R as the trial difference.
- One quotient bit is produced per cycle. Sign handling and RISC-V special cases are done in fixed pre/post cycles.

Parameters:
XLEN, 32, operand/result width in bits (power of two, >=8)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only on a rising edge where busy=0
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
a  input  XLEN  dividend (rs1), sampled on accept
b  input  XLEN  divisor (rs2), sampled on accept
kill  input  1  synchronous abort (pipeline flush)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid that cycle
result  output  XLEN  quotient or remainder per op; held until next accept

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst high at an edge forces state=IDLE, busy=0, done=0, result=0 and all internal registers to 0. rst has priority over kill and start, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 accepted:
  - Latch op and the signs of a and b (signed ops only). Load |a| and |b| (unsigned ops: raw values). Clear the remainder register. Set count=XLEN-1.
  - If b==0: set result = (REM/REMU ? a : all-ones) and go to DONE (fast path).
  - Else if a signed op has a==0x80..0 and b==all-ones: set result = (DIV ? 0x80..0 : 0) and go to DONE (fast path).
  - Otherwise go to CALC.
- CALC, one iteration per cycle:
  - Shift the {rem, dividend} pair left 1.
  - Trial diff = shifted rem - divisor via adder_subtractor, XLEN+1 bits.
  - If the diff MSB is 0: rem = diff and quotient bit = 1. Else keep the shifted rem and quotient bit = 0.
  - When count==0, go to FIX; else decrement count. CALC lasts exactly XLEN cycles.
- FIX:
  - Quotient is negated if sign(a) XOR sign(b) on a signed op.
  - Remainder is negated if sign(a) on a signed op.
  - result = quotient (DIV/DIVU) or remainder (REM/REMU). Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency, with the accept edge as cycle k:
  - Normal path: done is high during cycle k+XLEN+2, and busy is low again at k+XLEN+3.
  - Fast path: done is high during cycle k+1.
- Back-to-back: start can be accepted on the edge that leaves DONE only if busy is sampled 0. Therefore the next accept happens no earlier than the cycle after DONE.
- start while busy=1: ignored. No queuing, no effect on the current operation.
- kill=1 at an edge in CALC or FIX: go to IDLE, no done pulse, result unchanged from its prior value. kill in DONE: done is still seen that cycle and the state returns to IDLE. kill in IDLE has priority over start, so that start is dropped.
- result is registered and changes only on FIX or on a fast-path accept.
- Widths: all arithmetic is modulo 2^XLEN. Negation is two's complement. Magnitude of 0x80..0 is 0x80..0, taken as unsigned.

Test Plan (XLEN=32):
- DIVU a=100 b=7 -> result 14, done exactly 34 cycles after the accept edge, busy high for 34 cycles. Repeat with REMU -> result 2.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIV a=7 b=0xFFFFFFFE -> 0xFFFFFFFD.
- Divide by zero: DIVU a=5 b=0 -> 0xFFFFFFFF. REM a=0xFFFFFFFB b=0 -> 0xFFFFFFFB. Both give done 1 cycle after accept.
- Overflow: DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000. REM same -> 0, done after 1 cycle. DIVU with the same operands -> 0 via the normal 34-cycle path.
- start pulsed with new operands at cycle k+5 of a running DIVU 100/7 -> ignored, result 14. Then kill at k+10 of a second op -> no done, busy low next cycle, result still 14.
- rst asserted mid-CALC -> next cycle busy=0, done=0, result=0. A new DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF in 34 cycles.
